// File: rtl/ddram_rom_pkg.sv
// ddram_rom_pkg: shared constants and helpers for the cartridge ROM DDR3 port.
//   DEF_BASE_ADDR : default DDRAM_ADDR of ROM byte 0, in 8-byte words
//   S_*           : FSM state encodings (IDLE, WR, RD, RD_WAIT, DRAIN)
//   lane_be       : byte enables for one 16-bit lane of a 64-bit line
//   lane_word     : extract one 16-bit lane from a 64-bit line
package ddram_rom_pkg;

  localparam logic [28:0] DEF_BASE_ADDR = 29'h0600000;
  localparam int          DEF_AW        = 25;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD      = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  function automatic logic [7:0] lane_be(input logic [1:0] lane);
    return 8'b0000_0011 << {lane, 1'b0};
  endfunction

  function automatic logic [15:0] lane_word(input logic [63:0] line, input logic [1:0] lane);
    return line[{lane, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/ddram_rom_port_if.sv
// ddram_rom_port_if: loader/core toggle handshake plus the Avalon DDRAM_* bus.
//   slave  modport : the ddram_rom_port responder
//   master modport : the loader/core and DDR3 bridge side (testbench)
//   Request side : wraddr, din, we_req/we_ack, rdaddr, dout, rd_req/rd_ack
//   Avalon side  : DDRAM_BUSY, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DOUT,
//                  DDRAM_DOUT_READY, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
interface ddram_rom_port_if #(
  parameter int AW = 25
);
  logic [AW-1:0] wraddr;
  logic [15:0]   din;
  logic          we_req;
  logic          we_ack;
  logic [AW-2:0] rdaddr;
  logic [15:0]   dout;
  logic          rd_req;
  logic          rd_ack;

  logic          DDRAM_BUSY;
  logic [7:0]    DDRAM_BURSTCNT;
  logic [28:0]   DDRAM_ADDR;
  logic [63:0]   DDRAM_DOUT;
  logic          DDRAM_DOUT_READY;
  logic          DDRAM_RD;
  logic [63:0]   DDRAM_DIN;
  logic [7:0]    DDRAM_BE;
  logic          DDRAM_WE;

  modport slave (
    input  wraddr, din, we_req, rdaddr, rd_req,
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output we_ack, dout, rd_ack,
    output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );

  modport master (
    output wraddr, din, we_req, rdaddr, rd_req,
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  we_ack, dout, rd_ack,
    input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );
endinterface

// File: rtl/ddram_rom_cache.sv
// ddram_rom_cache: one-line read cache for ddram_rom_port (DDRAM_RDCACHE_EN builds).
//   clk, rst      : clock, synchronous active-high reset (invalidates the line)
//   fill_i        : store fill_data_i under tag fill_line_i
//   inval_i       : accepted write to inval_line_i; drops the line if it matches
//   look_line_i   : line being looked up; hit_o/data_o answer combinationally
module ddram_rom_cache
  import ddram_rom_pkg::*;
#(
  parameter int LW = DEF_AW - 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_i,
  input  logic [LW-1:0] fill_line_i,
  input  logic [63:0]   fill_data_i,
  input  logic          inval_i,
  input  logic [LW-1:0] inval_line_i,
  input  logic [LW-1:0] look_line_i,
  output logic          hit_o,
  output logic [63:0]   data_o
);
  logic          valid_q;
  logic [LW-1:0] tag_q;
  logic [63:0]   data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
    end else if (inval_i && (inval_line_i == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q  <= fill_line_i;
      data_q <= fill_data_i;
    end
  end

  assign hit_o  = valid_q && (tag_q == look_line_i);
  assign data_o = data_q;
endmodule

// File: rtl/ddram_rom_port.sv
// ddram_rom_port: responder side of the cartridge ROM toggle handshake.
// Turns 16-bit loader writes and core reads into single-beat 64-bit Avalon
// accesses on the DDR3 bridge, all in the clk_sys domain.
//   clk_sys : system clock (rising edge)
//   reset   : synchronous active-high; cancels pending requests
//   bus     : ddram_rom_port_if.slave (request handshakes + DDRAM_* bus)
// Optional: `define DDRAM_RDCACHE_EN adds a one-line read cache (ddram_rom_cache).
module ddram_rom_port
  import ddram_rom_pkg::*;
#(
  parameter logic [28:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          AW        = DEF_AW
) (
  input logic             clk_sys,
  input logic             reset,
  ddram_rom_port_if.slave bus
);
  localparam int LW = AW - 3;

  logic [2:0]    state_q, state_d, state_rst_d;
  logic          we_ack_q, we_ack_d;
  logic          rd_ack_q, rd_ack_d;
  logic          ddr_we_q, ddr_we_d;
  logic          ddr_rd_q, ddr_rd_d;
  logic [28:0]   addr_q, addr_d;
  logic [63:0]   din_q, din_d;
  logic [7:0]    be_q, be_d;
  logic [15:0]   dout_q, dout_d;
  logic [1:0]    lane_q, lane_d;

  logic          wr_pend, rd_pend;
  logic [LW-1:0] wr_line, rd_line;
  logic          cache_hit;
  logic [63:0]   cache_data;
  logic          unused_bits;

  assign wr_pend     = bus.we_req ^ we_ack_q;
  assign rd_pend     = bus.rd_req ^ rd_ack_q;
  assign wr_line     = bus.wraddr[AW-1:3];
  assign rd_line     = bus.rdaddr[AW-2:2];
  // Writes are always 16-bit aligned, so the byte bit carries no information.
  assign unused_bits = bus.wraddr[0];

`ifdef DDRAM_RDCACHE_EN
  // Line of the access in flight: fill tag for reads, invalidation key for writes.
  logic [LW-1:0] line_q, line_d;
  logic          cache_fill, cache_inval;

  assign cache_fill  = !reset && (state_q == S_RD_WAIT) && bus.DDRAM_DOUT_READY;
  assign cache_inval = !reset && (state_q == S_WR) && !bus.DDRAM_BUSY;

  ddram_rom_cache #(.LW(LW)) u_cache (
    .clk          (clk_sys),
    .rst          (reset),
    .fill_i       (cache_fill),
    .fill_line_i  (line_q),
    .fill_data_i  (bus.DDRAM_DOUT),
    .inval_i      (cache_inval),
    .inval_line_i (line_q),
    .look_line_i  (rd_line),
    .hit_o        (cache_hit),
    .data_o       (cache_data)
  );

  always_ff @(posedge clk_sys) begin
    line_q <= line_d;
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_comb begin
    state_d  = state_q;
    we_ack_d = we_ack_q;
    rd_ack_d = rd_ack_q;
    ddr_we_d = ddr_we_q;
    ddr_rd_d = ddr_rd_q;
    addr_d   = addr_q;
    din_d    = din_q;
    be_d     = be_q;
    dout_d   = dout_q;
    lane_d   = lane_q;
`ifdef DDRAM_RDCACHE_EN
    line_d   = line_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Write wins when both toggles are seen on the same edge.
        if (wr_pend) begin
          addr_d   = BASE_ADDR + 29'(wr_line);
          din_d    = {4{bus.din}};
          be_d     = lane_be(bus.wraddr[2:1]);
          ddr_we_d = 1'b1;
          state_d  = S_WR;
`ifdef DDRAM_RDCACHE_EN
          line_d   = wr_line;
`endif
        end else if (rd_pend) begin
          if (cache_hit) begin
            dout_d   = lane_word(cache_data, bus.rdaddr[1:0]);
            rd_ack_d = bus.rd_req;
          end else begin
            addr_d   = BASE_ADDR + 29'(rd_line);
            be_d     = 8'hFF;
            lane_d   = bus.rdaddr[1:0];
            ddr_rd_d = 1'b1;
            state_d  = S_RD;
`ifdef DDRAM_RDCACHE_EN
            line_d   = rd_line;
`endif
          end
        end
      end
      S_WR: begin
        if (!bus.DDRAM_BUSY) begin
          ddr_we_d = 1'b0;
          we_ack_d = bus.we_req;
          state_d  = S_IDLE;
        end
      end
      S_RD: begin
        if (!bus.DDRAM_BUSY) begin
          ddr_rd_d = 1'b0;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus.DDRAM_DOUT_READY) begin
          dout_d   = lane_word(bus.DDRAM_DOUT, lane_q);
          rd_ack_d = bus.rd_req;
          state_d  = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.DDRAM_DOUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Under reset, go to DRAIN whenever a read beat is still owed by the bridge:
  // a read already accepted (RD_WAIT, or RD accepted on this edge), or a drain
  // whose beat has not yet arrived. A beat arriving on the reset edge itself
  // settles the debt, so no drain is needed then.
  always_comb begin
    state_rst_d = S_IDLE;
    if (((state_q == S_RD_WAIT) || (state_q == S_DRAIN)) && !bus.DDRAM_DOUT_READY) begin
      state_rst_d = S_DRAIN;
    end else if ((state_q == S_RD) && !bus.DDRAM_BUSY) begin
      state_rst_d = S_DRAIN;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= state_rst_d;
      we_ack_q <= bus.we_req;
      rd_ack_q <= bus.rd_req;
      ddr_we_q <= 1'b0;
      ddr_rd_q <= 1'b0;
      addr_q   <= BASE_ADDR;
      din_q    <= '0;
      be_q     <= 8'hFF;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      we_ack_q <= we_ack_d;
      rd_ack_q <= rd_ack_d;
      ddr_we_q <= ddr_we_d;
      ddr_rd_q <= ddr_rd_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      be_q     <= be_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    lane_q <= lane_d;
  end

  assign bus.we_ack         = we_ack_q;
  assign bus.rd_ack         = rd_ack_q;
  assign bus.dout           = dout_q;
  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.DDRAM_ADDR     = addr_q;
  assign bus.DDRAM_DIN      = din_q;
  assign bus.DDRAM_BE       = be_q;
  assign bus.DDRAM_WE       = ddr_we_q;
  assign bus.DDRAM_RD       = ddr_rd_q;
endmodule
